// File: rtl/wb_stage.sv
// wb_stage: MEM->WB boundary buffer.
//   Retiring instructions are pushed into a small FIFO (valid/ready toward MEM).
//   The head entry drives the register-file write port combinationally.
//   Load data is extracted and extended at push time, so the head needs no further decode.
//   MOP entries carry both operands to the accumulator write path.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   me_valid / me_ready      upstream handshake (me_ready = entry count < DEPTH)
//   me_rd, me_regwrite, me_memtoreg, me_mop_en,
//   me_alu_result, me_rs2_data, me_load_data, me_load_funct3, me_addr_lo
//                            instruction fields from MEM
//   wb_stall                 hold the head entry, suppress the write strobe
//   wb_flush                 discard all entries and any concurrent push
//   w_regs_addr/data/data2/mop_en/en
//                            register-file write port; zero when the FIFO is empty
//
// Optional feature, enabled by defining WB_RETIRE_CNT_EN:
//   retire_cnt [31:0]        pop counter, wraps, cleared only by rst

module wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 6,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              me_valid,
  output logic              me_ready,
  input  logic [REG_AW-1:0] me_rd,
  input  logic              me_regwrite,
  input  logic              me_memtoreg,
  input  logic              me_mop_en,
  input  logic [XLEN-1:0]   me_alu_result,
  input  logic [XLEN-1:0]   me_rs2_data,
  input  logic [XLEN-1:0]   me_load_data,
  input  logic [2:0]        me_load_funct3,
  input  logic [1:0]        me_addr_lo,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic [REG_AW-1:0] w_regs_addr,
  output logic [XLEN-1:0]   w_regs_data,
  output logic [XLEN-1:0]   w_regs_data2,
  output logic              w_regs_mop_en,
  output logic              w_regs_en
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              mop;
    logic [XLEN-1:0]   data;
    logic [XLEN-1:0]   data2;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  entry_t          head, new_ent;
  logic            head_valid, push, pop;

  // Byte/half select and extension; anything not LB/LBU/LH/LHU is a full word.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_ext = {{(XLEN-8){b[7]}}, b};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, b};
      3'b001:  load_ext = {{(XLEN-16){h[15]}}, h};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, h};
      default: load_ext = word;
    endcase
  endfunction

  // Entry formed at push: MOP overrides rd/regwrite and ignores memtoreg.
  always_comb begin
    new_ent = '0;
    if (me_mop_en) begin
      new_ent.rd       = '0;
      new_ent.regwrite = 1'b1;
      new_ent.mop      = 1'b1;
      new_ent.data     = me_alu_result;
      new_ent.data2    = me_rs2_data;
    end else begin
      new_ent.rd       = me_rd;
      new_ent.regwrite = me_regwrite;
      new_ent.mop      = 1'b0;
      new_ent.data     = me_memtoreg ? load_ext(me_load_data, me_load_funct3, me_addr_lo)
                                     : me_alu_result;
      new_ent.data2    = '0;
    end
  end

  assign me_ready   = (count != FULL);
  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign push       = me_valid & me_ready & ~wb_flush;
  assign pop        = head_valid & ~wb_stall & ~wb_flush;

  // Payload storage needs no reset: it is only observed through head_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (wb_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    w_regs_addr   = '0;
    w_regs_data   = '0;
    w_regs_data2  = '0;
    w_regs_mop_en = 1'b0;
    if (head_valid) begin
      w_regs_addr   = head.rd;
      w_regs_data   = head.data;
      w_regs_data2  = head.data2;
      w_regs_mop_en = head.mop;
    end
  end

  // Strobe follows pop; regwrite=0 entries still pop, silently.
  assign w_regs_en = pop & head.regwrite;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      retire_cnt <= '0;
    else if (pop) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        me_valid = 1'b0;
  logic        me_ready;
  logic [5:0]  me_rd = '0;
  logic        me_regwrite = 1'b0;
  logic        me_memtoreg = 1'b0;
  logic        me_mop_en = 1'b0;
  logic [31:0] me_alu_result = '0;
  logic [31:0] me_rs2_data = '0;
  logic [31:0] me_load_data = '0;
  logic [2:0]  me_load_funct3 = '0;
  logic [1:0]  me_addr_lo = '0;
  logic        wb_stall = 1'b0;
  logic        wb_flush = 1'b0;
  logic [5:0]  w_regs_addr;
  logic [31:0] w_regs_data;
  logic [31:0] w_regs_data2;
  logic        w_regs_mop_en;
  logic        w_regs_en;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  logic [31:0] rc_before;
`endif

  int total = 0;
  int bad   = 0;

  wb_stage #(.XLEN(32), .REG_AW(6), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .me_valid(me_valid), .me_ready(me_ready),
    .me_rd(me_rd), .me_regwrite(me_regwrite), .me_memtoreg(me_memtoreg),
    .me_mop_en(me_mop_en), .me_alu_result(me_alu_result), .me_rs2_data(me_rs2_data),
    .me_load_data(me_load_data), .me_load_funct3(me_load_funct3), .me_addr_lo(me_addr_lo),
    .wb_stall(wb_stall), .wb_flush(wb_flush),
    .w_regs_addr(w_regs_addr), .w_regs_data(w_regs_data), .w_regs_data2(w_regs_data2),
    .w_regs_mop_en(w_regs_mop_en), .w_regs_en(w_regs_en)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  rd;
    logic        rw, m2r, mop;
    logic [31:0] alu, rs2, ld;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [5:0]  e_addr;
    logic [31:0] e_data, e_data2;
    logic        e_mop, e_en;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input vec_t v);
    me_rd = v.rd; me_regwrite = v.rw; me_memtoreg = v.m2r; me_mop_en = v.mop;
    me_alu_result = v.alu; me_rs2_data = v.rs2; me_load_data = v.ld;
    me_load_funct3 = v.f3; me_addr_lo = v.lo;
  endtask

  task automatic push_rd(input logic [5:0] rd);
    me_valid = 1'b1; me_rd = rd; me_regwrite = 1'b1; me_memtoreg = 1'b0;
    me_mop_en = 1'b0; me_alu_result = {26'h0, rd} + 32'h100;
  endtask

  initial begin
    //            rd  rw m2r mop alu          rs2          ld           f3      lo     addr data         data2        mop en
    vt[0]  = '{6'd5, 1, 0, 0, 32'h00001234, 32'h0,       32'h0,       3'b000, 2'd0, 6'd5, 32'h00001234, 32'h0,       0, 1};
    vt[1]  = '{6'd3, 1, 1, 0, 32'hDEAD0000, 32'h0,       32'h80FF7F01, 3'b000, 2'd3, 6'd3, 32'hFFFFFF80, 32'h0,       0, 1};
    vt[2]  = '{6'd4, 1, 1, 0, 32'h0,        32'h0,       32'h80FF7F01, 3'b101, 2'd2, 6'd4, 32'h000080FF, 32'h0,       0, 1};
    vt[3]  = '{6'd6, 1, 1, 0, 32'h0,        32'h0,       32'h80FF7F01, 3'b001, 2'd0, 6'd6, 32'h00007F01, 32'h0,       0, 1};
    vt[4]  = '{6'd8, 1, 1, 0, 32'h0,        32'h0,       32'h80FF7F01, 3'b100, 2'd1, 6'd8, 32'h0000007F, 32'h0,       0, 1};
    vt[5]  = '{6'd10,1, 1, 0, 32'h0,        32'h0,       32'h80FF7F01, 3'b001, 2'd3, 6'd10,32'hFFFF80FF, 32'h0,       0, 1};
    vt[6]  = '{6'd11,1, 1, 0, 32'h0,        32'h0,       32'h80FF7F01, 3'b010, 2'd2, 6'd11,32'h80FF7F01, 32'h0,       0, 1};
    vt[7]  = '{6'd12,1, 1, 0, 32'h0,        32'h0,       32'h80FF7F01, 3'b111, 2'd1, 6'd12,32'h80FF7F01, 32'h0,       0, 1};
    vt[8]  = '{6'd7, 0, 1, 1, 32'h01020304, 32'h02020202,32'hFFFFFFFF, 3'b000, 2'd0, 6'd0, 32'h01020304, 32'h02020202, 1, 1};
    vt[9]  = '{6'd9, 0, 0, 0, 32'h00000055, 32'h0,       32'h0,       3'b000, 2'd0, 6'd9, 32'h00000055, 32'h0,       0, 0};
    vt[10] = '{6'd0, 1, 0, 0, 32'hCAFEF00D, 32'h0,       32'h0,       3'b000, 2'd0, 6'd0, 32'hCAFEF00D, 32'h0,       0, 1};
    vt[11] = '{6'd13,1, 0, 0, 32'h00000777, 32'h12345678,32'h0,       3'b000, 2'd0, 6'd13,32'h00000777, 32'h0,       0, 1};

    // reset state
    #2;
    chk("rst_en", {31'b0, w_regs_en}, 32'd0);
    chk("rst_ready", {31'b0, me_ready}, 32'd1);
    chk("rst_addr", {26'b0, w_regs_addr}, 32'd0);
    chk("rst_data", w_regs_data, 32'd0);
    step();
    rst = 1'b0;
    step();

    // single-entry vectors: push, check head next cycle, check empty after pop
    for (int i = 0; i < 12; i++) begin
      set_in(vt[i]);
      me_valid = 1'b1;
      step();
      me_valid = 1'b0;
      #4;
      chk($sformatf("v%0d_addr", i), {26'b0, w_regs_addr}, {26'b0, vt[i].e_addr});
      chk($sformatf("v%0d_data", i), w_regs_data, vt[i].e_data);
      chk($sformatf("v%0d_data2", i), w_regs_data2, vt[i].e_data2);
      chk($sformatf("v%0d_mop", i), {31'b0, w_regs_mop_en}, {31'b0, vt[i].e_mop});
      chk($sformatf("v%0d_en", i), {31'b0, w_regs_en}, {31'b0, vt[i].e_en});
      chk($sformatf("v%0d_ready", i), {31'b0, me_ready}, 32'd1);
      step();
      #4;
      chk($sformatf("v%0d_empty_en", i), {31'b0, w_regs_en}, 32'd0);
      chk($sformatf("v%0d_empty_addr", i), {26'b0, w_regs_addr}, 32'd0);
      step();
    end

    // stall with 3 pushes offered into a 2-deep FIFO
    wb_stall = 1'b1;
    push_rd(6'd21);
    #4 chk("stall_rdy0", {31'b0, me_ready}, 32'd1);
    chk("stall_en0", {31'b0, w_regs_en}, 32'd0);
    step();
    push_rd(6'd22);
    #4 chk("stall_rdy1", {31'b0, me_ready}, 32'd1);
    chk("stall_en1", {31'b0, w_regs_en}, 32'd0);
    chk("stall_head1", {26'b0, w_regs_addr}, 32'd21);
    step();
    push_rd(6'd23);
    #4 chk("stall_rdy2", {31'b0, me_ready}, 32'd0);
    chk("stall_en2", {31'b0, w_regs_en}, 32'd0);
    step();
    me_valid = 1'b0;
    #4 chk("stall_en3", {31'b0, w_regs_en}, 32'd0);
    chk("stall_head3", {26'b0, w_regs_addr}, 32'd21);
    step();
    wb_stall = 1'b0;
    #4 chk("rel_en0", {31'b0, w_regs_en}, 32'd1);
    chk("rel_addr0", {26'b0, w_regs_addr}, 32'd21);
    chk("rel_data0", w_regs_data, 32'h115);
    step();
    #4 chk("rel_en1", {31'b0, w_regs_en}, 32'd1);
    chk("rel_addr1", {26'b0, w_regs_addr}, 32'd22);
    step();
    #4 chk("rel_en2", {31'b0, w_regs_en}, 32'd0);
    chk("rel_rdy2", {31'b0, me_ready}, 32'd1);
    step();

    // flush while full with a push offered
    wb_stall = 1'b1;
    push_rd(6'd24);
    step();
    push_rd(6'd25);
    step();
    me_valid = 1'b0;
    #4 chk("fl_full", {31'b0, me_ready}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    rc_before = retire_cnt;
`endif
    step();
    wb_stall = 1'b0;
    wb_flush = 1'b1;
    push_rd(6'd26);
    #4 chk("fl_en", {31'b0, w_regs_en}, 32'd0);
    step();
    wb_flush = 1'b0;
    me_valid = 1'b0;
    #4 chk("fl_ready", {31'b0, me_ready}, 32'd1);
    chk("fl_en_after", {31'b0, w_regs_en}, 32'd0);
    chk("fl_addr_after", {26'b0, w_regs_addr}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("fl_retire", retire_cnt, rc_before);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      #4 chk($sformatf("fl_quiet%0d", i), {31'b0, w_regs_en}, 32'd0);
    end
    step();

`ifdef WB_RETIRE_CNT_EN
    // one regwrite=0 pop still counts
    rc_before = retire_cnt;
    set_in(vt[9]);
    me_valid = 1'b1;
    step();
    me_valid = 1'b0;
    step();
    #4 chk("retire_inc", retire_cnt, rc_before + 32'd1);
    step();
`endif

    // async reset with 2 entries pending
    wb_stall = 1'b1;
    push_rd(6'd27);
    step();
    push_rd(6'd28);
    step();
    me_valid = 1'b0;
    wb_stall = 1'b0;
    #1 chk("ar_pre_en", {31'b0, w_regs_en}, 32'd1);
    #1 rst = 1'b1;
    #1 chk("ar_en", {31'b0, w_regs_en}, 32'd0);
    chk("ar_ready", {31'b0, me_ready}, 32'd1);
    chk("ar_addr", {26'b0, w_regs_addr}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4 chk($sformatf("ar_quiet%0d", i), {31'b0, w_regs_en}, 32'd0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
